// File: rtl/hartslag_teller.sv
// rtl/hartslag_teller.sv - heartbeat-rate meter: debounced beat counting per window,
// moving average over recent windows, overflow and loss-of-signal flags.
module hartslag_teller #(
  parameter int WINDOW_CYCLES = 100_000_000,
  parameter int CNT_W         = 8,
  parameter int DEBOUNCE      = 4,
  parameter int AVG_LOG2      = 2,
  parameter int NOSIG_WINDOWS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ingang,
  input  logic             enable,
  output logic             beat,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] avg,
  output logic             valid,
  output logic             avg_ready,
  output logic             overflow,
  output logic             no_signal
);

  localparam int TW    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int DW    = $clog2(DEBOUNCE + 1);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int SW    = CNT_W + AVG_LOG2;
  localparam int ZW    = $clog2(NOSIG_WINDOWS + 1);

  logic          sync_a, sync_b, f, f_q;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      f       <= 1'b0;
      f_q     <= 1'b0;
      deb_cnt <= '0;
      beat    <= 1'b0;
    end else begin
      sync_a <= ingang;
      sync_b <= sync_a;
      if (sync_b == f) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE - 1)) begin
        f       <= sync_b;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      f_q  <= f;
      beat <= f & ~f_q;
    end
  end

  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] run_cnt, run_next;
  logic             sticky, sticky_next, run_max, terminal;
  logic [CNT_W-1:0] hist [DEPTH];
  logic [PW-1:0]    ptr;
  logic [SW-1:0]    sum, sum_next;
  logic [FW-1:0]    fill;
  logic [ZW-1:0]    zcnt;

  // A beat in the terminal cycle still belongs to the window that is ending.
  assign run_max     = &run_cnt;
  assign run_next    = (beat && !run_max) ? run_cnt + CNT_W'(1) : run_cnt;
  assign sticky_next = sticky | (beat & run_max);
  assign terminal    = enable && (timer == TW'(WINDOW_CYCLES - 1));
  assign sum_next    = sum - SW'(hist[ptr]) + SW'(run_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer    <= '0;
      run_cnt  <= '0;
      sticky   <= 1'b0;
      valid    <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      ptr      <= '0;
      sum      <= '0;
      fill     <= '0;
      zcnt     <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        timer   <= '0;
        run_cnt <= '0;
        sticky  <= 1'b0;
      end else if (terminal) begin
        timer     <= '0;
        run_cnt   <= '0;
        sticky    <= 1'b0;
        valid     <= 1'b1;
        count     <= run_next;
        overflow  <= sticky_next;
        hist[ptr] <= run_next;
        sum       <= sum_next;
        ptr       <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        if (fill != FW'(DEPTH)) fill <= fill + FW'(1);
        if (run_next == '0) begin
          if (zcnt != ZW'(NOSIG_WINDOWS)) zcnt <= zcnt + ZW'(1);
        end else begin
          zcnt <= '0;
        end
      end else begin
        timer   <= timer + TW'(1);
        run_cnt <= run_next;
        sticky  <= sticky_next;
      end
    end
  end

  assign avg       = sum[SW-1:AVG_LOG2];
  assign avg_ready = (fill == FW'(DEPTH));
  assign no_signal = (zcnt == ZW'(NOSIG_WINDOWS));

endmodule
